id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage MIPS core. It registers the control word from the instruction decoder, together with operands and register addresses, for the EX stage. It detects load-use hazards and stalls upstream by inserting a bubble, and it squashes the decoded instruction on a branch or jump flush. Two saturating counters record bubbles and flushes.

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS core: load-use bubble insertion,
// flush squash, and saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_Jump,
  input  logic             id_JumpSrc,
  input  logic             id_isBranch,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc_A,
  input  logic             id_ALUSrc_B,
  input  logic             id_Sign,
  input  logic [1:0]       id_RegDst,
  input  logic [1:0]       id_MemtoReg,
  input  logic [3:0]       id_ALUOp,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [31:0]      id_pc4,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  input  logic             flush,
  input  logic             stall_in,
  output logic             ex_Jump,
  output logic             ex_JumpSrc,
  output logic             ex_isBranch,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc_A,
  output logic             ex_ALUSrc_B,
  output logic             ex_Sign,
  output logic [1:0]       ex_RegDst,
  output logic [1:0]       ex_MemtoReg,
  output logic [3:0]       ex_ALUOp,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_rs_data,
  output logic [31:0]      ex_rt_data,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_shamt,
  output logic             ex_valid,
  output logic             stall_out,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       Jump;
    logic       JumpSrc;
    logic       isBranch;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc_A;
    logic       ALUSrc_B;
    logic       Sign;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [3:0] ALUOp;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } data_t;

  // All control bits low, ALUOp = none (ALUOp occupies the low nibble).
  localparam ctrl_t BUBBLE = ctrl_t'({13'b0, 4'hF});

  ctrl_t ctrlD, ctrlQ;
  data_t dataD, dataQ;
  logic  validQ;
  logic  loadUse;

  assign ctrlD = '{Jump: id_Jump, JumpSrc: id_JumpSrc, isBranch: id_isBranch,
                   RegWrite: id_RegWrite, MemRead: id_MemRead, MemWrite: id_MemWrite,
                   ALUSrc_A: id_ALUSrc_A, ALUSrc_B: id_ALUSrc_B, Sign: id_Sign,
                   RegDst: id_RegDst, MemtoReg: id_MemtoReg, ALUOp: id_ALUOp};
  assign dataD = '{pc4: id_pc4, rsData: id_rs_data, rtData: id_rt_data, imm: id_imm,
                   rs: id_rs, rt: id_rt, rd: id_rd, shamt: id_shamt};

  // $0 is hardwired, so a load targeting it can never feed a consumer.
  assign loadUse = validQ & ctrlQ.MemRead & (dataQ.rt != 5'd0) &
                   ((id_use_rs & (dataQ.rt == id_rs)) | (id_use_rt & (dataQ.rt == id_rt)));
  assign stall_out = (stall_in | loadUse) & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrlQ      <= BUBBLE;
      dataQ      <= '0;
      validQ     <= 1'b0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush) begin
      ctrlQ  <= BUBBLE;
      dataQ  <= dataD;
      validQ <= 1'b0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (stall_in) begin
      ctrlQ  <= ctrlQ;
      dataQ  <= dataQ;
      validQ <= validQ;
    end else if (loadUse) begin
      ctrlQ  <= BUBBLE;
      dataQ  <= dataD;
      validQ <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      ctrlQ  <= ctrlD;
      dataQ  <= dataD;
      validQ <= 1'b1;
    end
  end

  assign ex_Jump     = ctrlQ.Jump;
  assign ex_JumpSrc  = ctrlQ.JumpSrc;
  assign ex_isBranch = ctrlQ.isBranch;
  assign ex_RegWrite = ctrlQ.RegWrite;
  assign ex_MemRead  = ctrlQ.MemRead;
  assign ex_MemWrite = ctrlQ.MemWrite;
  assign ex_ALUSrc_A = ctrlQ.ALUSrc_A;
  assign ex_ALUSrc_B = ctrlQ.ALUSrc_B;
  assign ex_Sign     = ctrlQ.Sign;
  assign ex_RegDst   = ctrlQ.RegDst;
  assign ex_MemtoReg = ctrlQ.MemtoReg;
  assign ex_ALUOp    = ctrlQ.ALUOp;
  assign ex_pc4      = dataQ.pc4;
  assign ex_rs_data  = dataQ.rsData;
  assign ex_rt_data  = dataQ.rtData;
  assign ex_imm      = dataQ.imm;
  assign ex_rs       = dataQ.rs;
  assign ex_rt       = dataQ.rt;
  assign ex_rd       = dataQ.rd;
  assign ex_shamt    = dataQ.shamt;
  assign ex_valid    = validQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written corner sequences,
// and random traffic against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       jump, jumpSrc, isBranch, regWrite, memRead, memWrite, aluSrcA, aluSrcB, sign;
    logic [1:0] regDst, memtoReg;
    logic [3:0] aluOp;
    logic [31:0] pc4, rsData, rtData, imm;
    logic [4:0] rs, rt, rd, shamt;
  } fields_t;

  typedef struct {
    fields_t f;
    logic    useRs, useRt, flush, stallIn;
  } in_t;

  typedef struct {
    fields_t f;
    logic    valid;
    int      bub, fl;
  } state_t;

  typedef struct {
    logic       flush, stallIn, memRead;
    logic [4:0] rs, rt;
    logic       useRs, useRt;
    logic [3:0] aluOp;
    logic       expStall, expValid;
    logic [3:0] expAlu;
    int         expBub, expFl;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic id_Jump, id_JumpSrc, id_isBranch, id_RegWrite, id_MemRead, id_MemWrite;
  logic id_ALUSrc_A, id_ALUSrc_B, id_Sign, id_use_rs, id_use_rt, flush, stall_in;
  logic [1:0] id_RegDst, id_MemtoReg;
  logic [3:0] id_ALUOp;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt;
  logic ex_Jump, ex_JumpSrc, ex_isBranch, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic ex_ALUSrc_A, ex_ALUSrc_B, ex_Sign, ex_valid, stall_out;
  logic [1:0] ex_RegDst, ex_MemtoReg;
  logic [3:0] ex_ALUOp;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int checks = 0, errors = 0;
  state_t model;
  vec_t tbl[15];

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_Jump(id_Jump), .id_JumpSrc(id_JumpSrc), .id_isBranch(id_isBranch),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_ALUSrc_A(id_ALUSrc_A), .id_ALUSrc_B(id_ALUSrc_B), .id_Sign(id_Sign),
    .id_RegDst(id_RegDst), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush(flush), .stall_in(stall_in),
    .ex_Jump(ex_Jump), .ex_JumpSrc(ex_JumpSrc), .ex_isBranch(ex_isBranch),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc_A(ex_ALUSrc_A), .ex_ALUSrc_B(ex_ALUSrc_B), .ex_Sign(ex_Sign),
    .ex_RegDst(ex_RegDst), .ex_MemtoReg(ex_MemtoReg), .ex_ALUOp(ex_ALUOp),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_valid(ex_valid), .stall_out(stall_out),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  function automatic state_t resetState();
    state_t s;
    s.f = '0; s.f.aluOp = 4'd15; s.valid = 1'b0; s.bub = 0; s.fl = 0;
    return s;
  endfunction

  // A bubble keeps the data/address fields but drops every control bit.
  function automatic fields_t bubbleOf(fields_t f);
    fields_t b = f;
    {b.jump, b.jumpSrc, b.isBranch, b.regWrite, b.memRead, b.memWrite,
     b.aluSrcA, b.aluSrcB, b.sign} = '0;
    b.regDst = 2'd0; b.memtoReg = 2'd0; b.aluOp = 4'd15;
    return b;
  endfunction

  function automatic logic hazard(state_t s, in_t x);
    if (!s.valid || !s.f.memRead || s.f.rt == 5'd0) return 1'b0;
    return (x.useRs && x.f.rs == s.f.rt) || (x.useRt && x.f.rt == s.f.rt);
  endfunction

  function automatic logic expStallOut(state_t s, in_t x);
    if (x.flush) return 1'b0;
    return x.stallIn || hazard(s, x);
  endfunction

  function automatic state_t nextState(state_t s, in_t x);
    state_t n = s;
    if (x.flush) begin
      n.f = bubbleOf(x.f); n.valid = 1'b0; n.fl = (s.fl == CMAX) ? CMAX : s.fl + 1;
    end else if (x.stallIn) begin
      n = s;
    end else if (hazard(s, x)) begin
      n.f = bubbleOf(x.f); n.valid = 1'b0; n.bub = (s.bub == CMAX) ? CMAX : s.bub + 1;
    end else begin
      n.f = x.f; n.valid = 1'b1;
    end
    return n;
  endfunction

  function automatic fields_t dutFields();
    return {ex_Jump, ex_JumpSrc, ex_isBranch, ex_RegWrite, ex_MemRead, ex_MemWrite,
            ex_ALUSrc_A, ex_ALUSrc_B, ex_Sign, ex_RegDst, ex_MemtoReg, ex_ALUOp,
            ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt};
  endfunction

  function automatic in_t randIn();
    in_t x;
    x.f = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    x.f.rs = 5'($urandom_range(0, 3));
    x.f.rt = 5'($urandom_range(0, 3));
    x.f.memRead = ($urandom_range(0, 9) < 4);
    x.useRs = 1'($urandom); x.useRt = 1'($urandom);
    x.flush = ($urandom_range(0, 9) == 0);
    x.stallIn = ($urandom_range(0, 6) == 0);
    return x;
  endfunction

  function automatic vec_t row(logic fl, logic st, logic mr, int rs, int rt, logic ur,
                               logic ut, int alu, logic eS, logic eV, int eA, int eB, int eF);
    vec_t v;
    v.flush = fl; v.stallIn = st; v.memRead = mr; v.rs = 5'(rs); v.rt = 5'(rt);
    v.useRs = ur; v.useRt = ut; v.aluOp = 4'(alu);
    v.expStall = eS; v.expValid = eV; v.expAlu = 4'(eA); v.expBub = eB; v.expFl = eF;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkState(input string tag);
    chk({tag, " fields"}, 256'(dutFields()), 256'(model.f));
    chk({tag, " ex_valid"}, 256'(ex_valid), 256'(model.valid));
    chk({tag, " bubble_cnt"}, 256'(bubble_cnt), 256'(model.bub));
    chk({tag, " flush_cnt"}, 256'(flush_cnt), 256'(model.fl));
  endtask

  task automatic drive(input in_t x);
    {id_Jump, id_JumpSrc, id_isBranch, id_RegWrite, id_MemRead, id_MemWrite,
     id_ALUSrc_A, id_ALUSrc_B, id_Sign, id_RegDst, id_MemtoReg, id_ALUOp,
     id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt} = x.f;
    id_use_rs = x.useRs; id_use_rt = x.useRt; flush = x.flush; stall_in = x.stallIn;
  endtask

  // Drive one cycle, check stall_out before the edge and full state after it.
  task automatic cycle(input in_t x, input string tag, output logic stallSeen);
    drive(x);
    #1;
    stallSeen = stall_out;
    chk({tag, " stall_out"}, 256'(stall_out), 256'(expStallOut(model, x)));
    @(posedge clk);
    model = nextState(model, x);
    #1;
    chkState(tag);
  endtask

  in_t x;
  logic st;
  state_t snap;

  initial begin
    x = randIn(); x.flush = 1'b0; x.stallIn = 1'b0;
    drive(x);
    model = resetState();
    @(negedge clk); @(negedge clk);
    chkState("reset");
    reset_n = 1'b1;

    tbl[0]  = row(0, 0, 1, 9, 8, 1, 0, 0,  0, 1, 0,  0, 0);
    tbl[1]  = row(0, 0, 0, 8, 10, 1, 1, 2, 1, 0, 15, 1, 0);
    tbl[2]  = row(0, 0, 0, 8, 10, 1, 1, 2, 0, 1, 2,  1, 0);
    tbl[3]  = row(0, 0, 1, 9, 0, 1, 0, 0,  0, 1, 0,  1, 0);
    tbl[4]  = row(0, 0, 0, 0, 0, 1, 1, 3,  0, 1, 3,  1, 0);
    tbl[5]  = row(0, 0, 1, 1, 12, 1, 0, 0, 0, 1, 0,  1, 0);
    tbl[6]  = row(0, 0, 0, 3, 12, 1, 0, 4, 0, 1, 4,  1, 0);
    tbl[7]  = row(0, 0, 1, 1, 5, 1, 0, 0,  0, 1, 0,  1, 0);
    tbl[8]  = row(1, 0, 0, 5, 0, 1, 0, 6,  0, 0, 15, 1, 1);
    tbl[9]  = row(0, 1, 1, 2, 7, 1, 0, 0,  1, 0, 15, 1, 1);
    tbl[10] = row(0, 0, 1, 2, 7, 1, 0, 0,  0, 1, 0,  1, 1);
    tbl[11] = row(0, 1, 0, 0, 7, 0, 1, 5,  1, 1, 0,  1, 1);
    tbl[12] = row(0, 0, 0, 0, 7, 0, 1, 5,  1, 0, 15, 2, 1);
    tbl[13] = row(0, 0, 0, 0, 7, 0, 1, 5,  0, 1, 5,  2, 1);
    tbl[14] = row(1, 1, 1, 4, 9, 1, 1, 0,  0, 0, 15, 2, 2);
    for (int i = 0; i < 15; i++) begin
      x = randIn();
      x.flush = tbl[i].flush; x.stallIn = tbl[i].stallIn; x.f.memRead = tbl[i].memRead;
      x.f.rs = tbl[i].rs; x.f.rt = tbl[i].rt; x.useRs = tbl[i].useRs;
      x.useRt = tbl[i].useRt; x.f.aluOp = tbl[i].aluOp;
      cycle(x, $sformatf("vec%0d", i), st);
      chk($sformatf("vec%0d stall", i), 256'(st), 256'(tbl[i].expStall));
      chk($sformatf("vec%0d valid", i), 256'(ex_valid), 256'(tbl[i].expValid));
      chk($sformatf("vec%0d aluop", i), 256'(ex_ALUOp), 256'(tbl[i].expAlu));
      chk($sformatf("vec%0d bub", i), 256'(bubble_cnt), 256'(tbl[i].expBub));
      chk($sformatf("vec%0d fl", i), 256'(flush_cnt), 256'(tbl[i].expFl));
    end

    // Downstream hold for three cycles with changing ID contents.
    snap = model;
    for (int i = 0; i < 3; i++) begin
      x = randIn(); x.flush = 1'b0; x.stallIn = 1'b1;
      cycle(x, "hold", st);
      chk("hold stall_out", 256'(st), 256'(1));
    end
    chk("hold fields", 256'(dutFields()), 256'(snap.f));
    chk("hold valid", 256'(ex_valid), 256'(snap.valid));
    chk("hold counters", 256'({bubble_cnt, flush_cnt}), 256'({CNT_W'(snap.bub), CNT_W'(snap.fl)}));

    // Drive both counters past all-ones.
    for (int i = 0; i < CMAX + 3; i++) begin
      x = randIn(); x.flush = 0; x.stallIn = 0; x.f.memRead = 1; x.f.rt = 5'd3;
      cycle(x, "satLw", st);
      x = randIn(); x.flush = 0; x.stallIn = 0; x.f.memRead = 0; x.f.rs = 5'd3; x.useRs = 1;
      cycle(x, "satUse", st);
    end
    chk("bubble_cnt saturated", 256'(bubble_cnt), 256'(CMAX));
    for (int i = 0; i < CMAX + 3; i++) begin
      x = randIn(); x.flush = 1'b1;
      cycle(x, "satFlush", st);
    end
    chk("flush_cnt saturated", 256'(flush_cnt), 256'(CMAX));

    for (int i = 0; i < 3000; i++) begin
      x = randIn();
      cycle(x, "rand", st);
    end

    // Asynchronous reset mid-cycle with a live instruction in EX.
    x = randIn(); x.flush = 0; x.stallIn = 0; x.f.memRead = 0;
    cycle(x, "preReset", st);
    chk("preReset valid", 256'(ex_valid), 256'(1));
    #2 reset_n = 1'b0;
    #1;
    model = resetState();
    chkState("asyncReset");
    @(negedge clk);
    reset_n = 1'b1;
    x = randIn(); x.flush = 0; x.stallIn = 0;
    cycle(x, "postReset", st);
    chk("postReset valid", 256'(ex_valid), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
